cache_lru_tracker: RTL and testbench

//  Per-set replacement-state keeper for the 2-way set-associative cache; sits directly upstream of the
//  age-adjust stage: reads both way ages of the addressed set, feeds old ages + hit/miss to

---
 rtl/cache_lru_tracker_pkg.sv | 40 ++++
 rtl/cache_age_update.sv | 22 ++
 rtl/cache_lru_tracker.sv | 170 +++++++++++++++++
 tb/tb_cache_lru_tracker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_lru_tracker_pkg.sv
// Shared types and helpers for the 2-way LRU replacement tracker.
// Also holds the victim-select rule, so the cache controller can apply the same choice.
package cache_lru_tracker_pkg;

    localparam int unsigned NUM_SETS = 64;
    localparam int unsigned SET_W    = 6;
    localparam int unsigned AGE_W    = 2;

    typedef logic [AGE_W-1:0] age_t;
    typedef logic [SET_W-1:0] set_t;

    localparam age_t AGE_MAX = {AGE_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_UPDATE,
        ST_RESP,
        ST_FLUSH
    } state_e;

    typedef struct packed {
        set_t set;
        logic hit;
        logic hit_way;
    } req_t;

    // Fill an invalid way first (way 0 before way 1), else the older way; a tie picks way 0.
    function automatic logic select_way(input logic v0, input logic v1,
                                        input age_t age0, input age_t age1);
        if (!v0) return 1'b0;
        if (!v1) return 1'b1;
        return (age1 > age0);
    endfunction

    function automatic age_t age_sat_inc(input age_t a);
        return (a == AGE_MAX) ? AGE_MAX : a + AGE_W'(1);
    endfunction

endpackage

// File: rtl/cache_age_update.sv
// Combinational age/valid update for one set: the accessed way becomes youngest,
// the other way ages by one (saturating); a miss fills the way and may evict it.
module cache_age_update
    import cache_lru_tracker_pkg::*;
(
    input  age_t i_age0,
    input  age_t i_age1,
    input  logic i_way,
    input  logic i_hit,
    input  logic i_way_valid,
    output age_t o_age0_c,
    output age_t o_age1_c,
    output logic o_fill_c,
    output logic o_evict_c
);

    assign o_age0_c  = i_way ? age_sat_inc(i_age0) : '0;
    assign o_age1_c  = i_way ? '0 : age_sat_inc(i_age1);
    assign o_fill_c  = !i_hit;
    assign o_evict_c = !i_hit && i_way_valid;

endmodule

// File: rtl/cache_lru_tracker.sv
// Per-set replacement-state keeper for a 2-way set-associative cache:
// read ages/valid of the set, pick hit or victim way, write back, report way and evict.
module cache_lru_tracker
    import cache_lru_tracker_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic             req_hit,
    input  logic             req_hit_way,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_way,
    output logic             rsp_evict,
    input  logic             flush,
    output logic             flush_busy
);

    state_e r_state;
    state_e w_state_next;

    req_t  r_req;
    age_t  r_age0 [NUM_SETS];
    age_t  r_age1 [NUM_SETS];
    logic [NUM_SETS-1:0] r_v0;
    logic [NUM_SETS-1:0] r_v1;

    age_t  r_rd_age0;
    age_t  r_rd_age1;
    logic  r_rd_v0;
    logic  r_rd_v1;

    set_t  r_flush_cnt;
    logic  r_flush_pend;
    logic  r_req_ready;
    logic  r_rsp_valid;
    logic  r_rsp_way;
    logic  r_rsp_evict;

    logic  w_accept;
    logic  w_flush_pend_next;
    logic  w_req_ready_next;
    logic  w_sel_way;
    logic  w_sel_valid;
    age_t  w_new_age0;
    age_t  w_new_age1;
    logic  w_fill;
    logic  w_evict;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; a pending flush wins over a request in IDLE
    always_comb begin
        w_state_next      = r_state;
        w_accept          = 1'b0;
        w_flush_pend_next = r_flush_pend | flush;
        case (r_state)
            ST_IDLE: begin
                if (r_flush_pend) begin
                    w_state_next = ST_FLUSH;
                end else if (req_valid && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_READ:   w_state_next = ST_UPDATE;
            ST_UPDATE: w_state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            ST_FLUSH: begin
                if (r_flush_cnt == SET_W'(NUM_SETS - 1)) begin
                    w_state_next      = ST_IDLE;
                    w_flush_pend_next = 1'b0;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_req_ready_next = (w_state_next == ST_IDLE) && !w_flush_pend_next;
    end

    assign w_sel_way   = r_req.hit ? r_req.hit_way
                                   : select_way(r_rd_v0, r_rd_v1, r_rd_age0, r_rd_age1);
    assign w_sel_valid = w_sel_way ? r_rd_v1 : r_rd_v0;

    cache_age_update u_age_update (
        .i_age0      (r_rd_age0),
        .i_age1      (r_rd_age1),
        .i_way       (w_sel_way),
        .i_hit       (r_req.hit),
        .i_way_valid (w_sel_valid),
        .o_age0_c    (w_new_age0),
        .o_age1_c    (w_new_age1),
        .o_fill_c    (w_fill),
        .o_evict_c   (w_evict)
    );

    // Control, read snapshot and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req        <= '0;
            r_rd_age0    <= '0;
            r_rd_age1    <= '0;
            r_rd_v0      <= 1'b0;
            r_rd_v1      <= 1'b0;
            r_flush_cnt  <= '0;
            r_flush_pend <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_way    <= 1'b0;
            r_rsp_evict  <= 1'b0;
        end else begin
            r_flush_pend <= w_flush_pend_next;
            r_req_ready  <= w_req_ready_next;
            r_rsp_valid  <= (w_state_next == ST_RESP);
            if (w_accept) begin
                r_req <= '{set: req_set, hit: req_hit, hit_way: req_hit_way};
            end
            if (r_state == ST_READ) begin
                r_rd_age0 <= r_age0[r_req.set];
                r_rd_age1 <= r_age1[r_req.set];
                r_rd_v0   <= r_v0[r_req.set];
                r_rd_v1   <= r_v1[r_req.set];
            end
            if (r_state == ST_UPDATE) begin
                r_rsp_way   <= w_sel_way;
                r_rsp_evict <= w_evict;
            end
            r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + SET_W'(1) : '0;
        end
    end

    // Per-set storage: written back at the end of UPDATE, cleared one set per FLUSH cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_age0 <= '{default: '0};
            r_age1 <= '{default: '0};
            r_v0   <= '0;
            r_v1   <= '0;
        end else if (r_state == ST_UPDATE) begin
            r_age0[r_req.set] <= w_new_age0;
            r_age1[r_req.set] <= w_new_age1;
            if (w_fill) begin
                if (w_sel_way) r_v1[r_req.set] <= 1'b1;
                else           r_v0[r_req.set] <= 1'b1;
            end
        end else if (r_state == ST_FLUSH) begin
            r_age0[r_flush_cnt] <= '0;
            r_age1[r_flush_cnt] <= '0;
            r_v0[r_flush_cnt]   <= 1'b0;
            r_v1[r_flush_cnt]   <= 1'b0;
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_way    = r_rsp_way;
    assign rsp_evict  = r_rsp_evict;
    assign flush_busy = r_flush_pend;

endmodule

// File: tb/tb_cache_lru_tracker.sv
// Self-checking bench for cache_lru_tracker: directed vector table, hand sequences
// for stall/flush/reset corners, and random traffic against a per-set age/valid model.
module tb_cache_lru_tracker;

    localparam int NS   = 64;
    localparam int AMAX = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_set;
    logic       req_hit;
    logic       req_hit_way;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_way;
    logic       rsp_evict;
    logic       flush;
    logic       flush_busy;

    cache_lru_tracker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_set     (req_set),
        .req_hit     (req_hit),
        .req_hit_way (req_hit_way),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_way     (rsp_way),
        .rsp_evict   (rsp_evict),
        .flush       (flush),
        .flush_busy  (flush_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ages and valid bits per set and way
    int m_age [NS][2];
    int m_v   [NS][2];

    typedef struct {
        int s;
        int hit;
        int hw;
        int exp_way;
        int exp_ev;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NS; i++) begin
            m_age[i][0] = 0; m_age[i][1] = 0;
            m_v[i][0]   = 0; m_v[i][1]   = 0;
        end
    endfunction

    function automatic void model_access(input int s, input int hit, input int hw,
                                         output int way, output int ev);
        int other;
        if (hit != 0)           way = hw;
        else if (m_v[s][0] == 0) way = 0;
        else if (m_v[s][1] == 0) way = 1;
        else                     way = (m_age[s][1] > m_age[s][0]) ? 1 : 0;
        ev    = (hit == 0 && m_v[s][way] != 0) ? 1 : 0;
        other = 1 - way;
        m_age[s][way]   = 0;
        m_age[s][other] = (m_age[s][other] + 1 > AMAX) ? AMAX : m_age[s][other] + 1;
        if (hit == 0) m_v[s][way] = 1;
    endfunction

    function automatic void add_vec(input int s, input int hit, input int hw,
                                    input int ew, input int ee);
        vec_t v;
        v.s = s; v.hit = hit; v.hw = hw; v.exp_way = ew; v.exp_ev = ee;
        vq.push_back(v);
    endfunction

    // Issue one request (rsp_ready assumed 1); called and returns just after a rising edge
    task automatic do_req(input int s, input int hit, input int hw,
                          output int way, output int ev, output int lat);
        int waitc = 0;
        req_valid   = 1'b1;
        req_set     = 6'(s);
        req_hit     = hit[0];
        req_hit_way = hw[0];
        while (!req_ready && waitc < 300) begin
            @(posedge clk); #1; waitc++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            way = -1; ev = -1; lat = -1;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        way = rsp_valid ? int'(rsp_way) : -1;
        ev  = rsp_valid ? int'(rsp_evict) : -1;
        @(posedge clk); #1;
    endtask

    task automatic req_vs_model(input string name, input int s, input int hit, input int hw);
        int way, ev, lat, ew, ee;
        model_access(s, hit, hw, ew, ee);
        do_req(s, hit, hw, way, ev, lat);
        chk({name, "_way"}, way, ew);
        chk({name, "_evict"}, ev, ee);
        chk({name, "_latency"}, lat, 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int way, ev, lat, ew, ee, busy, bad, waitc;

        rst_n = 1'b0; req_valid = 1'b0; req_set = '0; req_hit = 1'b0;
        req_hit_way = 1'b0; rsp_ready = 1'b1; flush = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_way", int'(rsp_way), 0);
        chk("reset_rsp_evict", int'(rsp_evict), 0);
        chk("reset_flush_busy", int'(flush_busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: {set, hit, hit_way, expected way, expected evict}
        add_vec(5, 0, 0, 0, 0);
        add_vec(5, 0, 0, 1, 0);
        add_vec(5, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add_vec(5, 1, 1, 1, 0);
        add_vec(5, 0, 0, 0, 1);
        add_vec(9, 1, 1, 1, 0);
        add_vec(9, 0, 0, 0, 0);
        add_vec(9, 0, 0, 1, 0);
        add_vec(63, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 1, 0);
        add_vec(0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 1, 1);
        add_vec(7, 0, 0, 0, 0);
        add_vec(7, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) add_vec(7, 1, 0, 0, 0);
        add_vec(7, 0, 0, 1, 1);

        foreach (vq[i]) begin
            model_access(vq[i].s, vq[i].hit, vq[i].hw, ew, ee);
            do_req(vq[i].s, vq[i].hit, vq[i].hw, way, ev, lat);
            chk($sformatf("vec%0d_way", i), way, vq[i].exp_way);
            chk($sformatf("vec%0d_evict", i), ev, vq[i].exp_ev);
            chk($sformatf("vec%0d_latency", i), lat, 3);
        end

        // Response held while consumer stalls
        model_access(20, 0, 0, ew, ee);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_set = 6'd20; req_hit = 1'b0; req_hit_way = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waitc = 0;
        while (!rsp_valid && waitc < 20) begin @(posedge clk); #1; waitc++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", int'(rsp_valid), 1);
            chk("stall_rsp_way", int'(rsp_way), ew);
            chk("stall_rsp_evict", int'(rsp_evict), ee);
            chk("stall_req_ready", int'(req_ready), 0);
            @(posedge clk); #1;
        end
        chk("stall_still_valid", int'(rsp_valid), 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_rsp_valid", int'(rsp_valid), 0);
        chk("stall_release_req_ready", int'(req_ready), 1);

        // Flush raised during UPDATE while a second request waits
        model_access(3, 0, 0, ew, ee);
        req_valid = 1'b1; req_set = 6'd3; req_hit = 1'b0; req_hit_way = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        req_valid = 1'b1; req_set = 6'd5; req_hit = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_resp_valid", int'(rsp_valid), 1);
        chk("fl_resp_way", int'(rsp_way), ew);
        chk("fl_resp_evict", int'(rsp_evict), ee);
        model_clear();
        busy = 0; bad = 0;
        while (flush_busy && busy < 300) begin
            busy++;
            if (req_ready) bad++;
            flush = (busy == 30);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        chk("fl_busy_cycles", busy, 66);
        chk("fl_ready_while_busy", bad, 0);
        chk("fl_ready_after", int'(req_ready), 1);
        model_access(5, 0, 0, ew, ee);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("fl_next_latency", lat, 3);
        chk("fl_next_way", int'(rsp_way), ew);
        chk("fl_next_evict", int'(rsp_evict), ee);
        @(posedge clk); #1;

        // Random traffic with occasional flushes
        for (int n = 0; n < 250; n++) begin
            int s;
            if ($urandom_range(0, 15) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                busy = 0;
                while (flush_busy && busy < 300) begin @(posedge clk); #1; busy++; end
                chk("rnd_flush_cycles", busy, 65);
                model_clear();
            end
            s = $urandom_range(0, 15);
            if (s >= 8) s += 32;
            req_vs_model($sformatf("rnd%0d", n), s, int'($urandom_range(0, 2) == 0),
                         int'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Reset in the middle of a flush at count 20
        req_vs_model("pre_rst_a", 5, 0, 0);
        req_vs_model("pre_rst_b", 5, 0, 0);
        req_vs_model("pre_rst_c", 40, 0, 0);
        req_vs_model("pre_rst_d", 40, 0, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (21) begin @(posedge clk); #1; end
        chk("mid_flush_busy", int'(flush_busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_flush_busy", int'(flush_busy), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        rst_n = 1'b1;
        model_clear();
        do_req(40, 0, 0, way, ev, lat);
        chk("post_rst_s40_way", way, 0);
        chk("post_rst_s40_evict", ev, 0);
        do_req(5, 0, 0, way, ev, lat);
        chk("post_rst_s5_way", way, 0);
        chk("post_rst_s5_evict", ev, 0);
        do_req(5, 0, 0, way, ev, lat);
        chk("post_rst_s5b_way", way, 1);
        chk("post_rst_s5b_evict", ev, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
